// File: rtl/y86_inst_rom.sv
// Y86 instruction memory: combinational unaligned multi-byte fetch port plus a
// byte-serial framed loader (4-byte LE base, 2-byte LE length, then data).
module y86_inst_rom #(
  parameter int PC_W       = 32,
  parameter int INST_BYTES = 6,
  parameter int DEPTH      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PC_W-1:0]         rom_addr_i,
  output logic [8*INST_BYTES-1:0] rom_data_o,
  input  logic                    ld_valid,
  input  logic [7:0]              ld_data,
  output logic                    ld_ready,
  output logic                    ld_busy,
  output logic                    ld_done,
  output logic                    ld_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [PC_W:0] DEPTH_EXT = (PC_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_ADDR, S_LEN, S_DATA, S_DONE} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] base;
  logic [15:0] len;
  logic [15:0] idx;
  logic [7:0]  mem [DEPTH];

  logic        accept;
  logic [32:0] wr_addr;
  logic        wr_in_range;

  assign ld_ready    = !rst && (state != S_DONE);
  assign ld_busy     = (state != S_ADDR) || (cnt != 2'd0);
  assign ld_done     = (state == S_DONE);
  assign accept      = ld_valid && ld_ready;
  // 33-bit sum so a base near 2^32 cannot wrap back into the array.
  assign wr_addr     = {1'b0, base} + {17'd0, idx};
  assign wr_in_range = wr_addr < 33'(DEPTH);

  // NOTE: the array has no reset branch on purpose; program contents survive
  // rst, and a reset loop over every byte would not map onto a RAM.
  always_ff @(posedge clk) begin
    if (accept && (state == S_DATA) && wr_in_range)
      mem[wr_addr[AW-1:0]] <= ld_data;
  end

  // Each fetched byte is independently range-checked so a fetch straddling
  // the top of memory (or the top of the address space) pads with zeros.
  for (genvar k = 0; k < INST_BYTES; k++) begin : g_fetch
    logic [PC_W:0] addr;
    assign addr = {1'b0, rom_addr_i} + (PC_W+1)'(k);
    assign rom_data_o[8*(INST_BYTES-1-k) +: 8] =
      (rst || addr >= DEPTH_EXT) ? 8'h00 : mem[addr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_ADDR;
      cnt    <= 2'd0;
      base   <= '0;
      len    <= '0;
      idx    <= '0;
      ld_err <= 1'b0;
    end else begin
      case (state)
        S_ADDR: if (accept) begin
          base[8*cnt +: 8] <= ld_data;
          if (cnt == 2'd3) begin
            cnt   <= 2'd0;
            state <= S_LEN;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_LEN: if (accept) begin
          if (cnt == 2'd0) begin
            len[7:0] <= ld_data;
            cnt      <= 2'd1;
          end else begin
            len[15:8] <= ld_data;
            cnt       <= 2'd0;
            idx       <= '0;
            state     <= ({ld_data, len[7:0]} == 16'd0) ? S_DONE : S_DATA;
          end
        end
        S_DATA: if (accept) begin
          if (!wr_in_range) ld_err <= 1'b1;
          idx <= idx + 16'd1;
          if (idx == len - 16'd1) state <= S_DONE;
        end
        S_DONE:  state <= S_ADDR;
        default: state <= S_ADDR;
      endcase
    end
  end

endmodule
